// File: rtl/sram_stream_pkg.sv
// Shared types for the SRAM burst read initiator.
// The FIFO entry type depends on DataWidth, so it lives in the top module.
package sram_stream_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2
    } state_e;

endpackage

// File: rtl/sram_stream_reader_fifo.sv
// Return buffer for SRAM read data.
// Output comes from storage, so a pushed word is visible one cycle later.
module sram_stream_reader_fifo #(
    parameter int Width = 8,
    parameter int Depth = 4
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_push,
    input  logic [Width-1:0] i_data,
    input  logic             i_pop,
    output logic [Width-1:0] o_data,
    output logic             o_full,
    output logic             o_empty
);

    localparam int PtrW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int CntW = $clog2(Depth + 1);

    logic [Width-1:0] r_mem [Depth];
    logic [PtrW-1:0]  r_wp;
    logic [PtrW-1:0]  r_rp;
    logic [CntW-1:0]  r_cnt;

    // Pointers wrap explicitly so any depth works, not just powers of two.
    function automatic logic [PtrW-1:0] bump(input logic [PtrW-1:0] p);
        return (p == PtrW'(Depth - 1)) ? '0 : p + PtrW'(1);
    endfunction

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wp  <= '0;
            r_rp  <= '0;
            r_cnt <= '0;
            for (int i = 0; i < Depth; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (i_push) begin
                r_mem[r_wp] <= i_data;
                r_wp        <= bump(r_wp);
            end
            if (i_pop) begin
                r_rp <= bump(r_rp);
            end
            case ({i_push, i_pop})
                2'b10:   r_cnt <= r_cnt + CntW'(1);
                2'b01:   r_cnt <= r_cnt - CntW'(1);
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    assign o_data  = r_mem[r_rp];
    assign o_full  = (r_cnt == CntW'(Depth));
    assign o_empty = (r_cnt == '0);

endmodule

// File: rtl/sram_stream_reader.sv
// Burst read initiator: issues one SRAM read per cycle under a credit limit
// and returns the words in order on a valid/ready stream.
module sram_stream_reader
    import sram_stream_pkg::*;
#(
    parameter  int NumWords  = 1024,
    parameter  int DataWidth = 128,
    parameter  int ByteWidth = 8,
    parameter  int Latency   = 1,
    parameter  int FifoDepth = 4,
    parameter  int LenWidth  = 16,
    localparam int AddrWidth = (NumWords > 1) ? $clog2(NumWords) : 1,
    localparam int BeWidth   = (DataWidth + ByteWidth - 1) / ByteWidth
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 cmd_valid_i,
    output logic                 cmd_ready_o,
    input  logic [AddrWidth-1:0] cmd_addr_i,
    input  logic [LenWidth-1:0]  cmd_len_i,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 req_o,
    output logic                 we_o,
    output logic [AddrWidth-1:0] addr_o,
    output logic [DataWidth-1:0] wdata_o,
    output logic [BeWidth-1:0]   be_o,
    input  logic [DataWidth-1:0] rdata_i,
    output logic                 data_valid_o,
    input  logic                 data_ready_i,
    output logic [DataWidth-1:0] data_o,
    output logic                 data_last_o
);

    typedef struct packed {
        logic [DataWidth-1:0] data;
        logic                 last;
    } entry_t;

    localparam int CntW = $clog2(FifoDepth + 1);

    state_e               r_state;
    state_e               w_next;
    logic [AddrWidth-1:0] r_addr;
    logic [LenWidth-1:0]  r_rem;
    logic [CntW-1:0]      r_out;
    logic                 r_done;

    logic   w_accept;
    logic   w_zero;
    logic   w_req;
    logic   w_req_last;
    logic   w_pop;
    logic   w_push;
    logic   w_push_last;
    logic   w_full;
    logic   w_empty;
    entry_t w_wr;
    entry_t w_rd;

    assign w_accept   = cmd_valid_i & cmd_ready_o;
    assign w_zero     = (cmd_len_i == '0);
    assign w_req_last = (r_rem == LenWidth'(1));
    assign w_pop      = data_valid_o & data_ready_i;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_accept && !w_zero) w_next = ISSUE;
            ISSUE:   if (w_req && w_req_last) w_next = DRAIN;
            DRAIN:   if (w_pop && data_last_o) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Requests are throttled so in-flight plus buffered words never exceed the FIFO.
    always_comb begin
        cmd_ready_o = 1'b0;
        busy_o      = 1'b0;
        w_req       = 1'b0;
        case (r_state)
            IDLE:  cmd_ready_o = !rst_i;
            ISSUE: begin
                busy_o = 1'b1;
                w_req  = (r_out < CntW'(FifoDepth));
            end
            DRAIN: busy_o = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_addr <= '0;
            r_rem  <= '0;
            r_done <= 1'b0;
        end else begin
            r_done <= (w_accept && w_zero) ||
                      (r_state == DRAIN && w_pop && data_last_o);
            if (w_accept) begin
                r_addr <= cmd_addr_i;
                r_rem  <= cmd_len_i;
            end else if (w_req) begin
                r_addr <= (r_addr == AddrWidth'(NumWords - 1)) ?
                          '0 : r_addr + AddrWidth'(1);
                r_rem  <= r_rem - LenWidth'(1);
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_out <= '0;
        end else begin
            case ({w_req, w_pop})
                2'b10:   r_out <= r_out + CntW'(1);
                2'b01:   r_out <= r_out - CntW'(1);
                default: r_out <= r_out;
            endcase
        end
    end

    generate
        if (Latency == 0) begin : g_nolat
            assign w_push      = w_req;
            assign w_push_last = w_req & w_req_last;
        end else begin : g_lat
            logic [Latency-1:0] r_pv;
            logic [Latency-1:0] r_pl;
            always_ff @(posedge clk_i or posedge rst_i) begin
                if (rst_i) begin
                    r_pv <= '0;
                    r_pl <= '0;
                end else begin
                    r_pv <= (r_pv << 1) | Latency'(w_req);
                    r_pl <= (r_pl << 1) | Latency'(w_req & w_req_last);
                end
            end
            assign w_push      = r_pv[Latency-1];
            assign w_push_last = r_pl[Latency-1];
        end
    endgenerate

    assign w_wr.data = rdata_i;
    assign w_wr.last = w_push_last;

    sram_stream_reader_fifo #(
        .Width($bits(entry_t)),
        .Depth(FifoDepth)
    ) u_fifo (
        .i_clk  (clk_i),
        .i_rst  (rst_i),
        .i_push (w_push),
        .i_data (w_wr),
        .i_pop  (w_pop),
        .o_data (w_rd),
        .o_full (w_full),
        .o_empty(w_empty)
    );

    assert property (@(posedge clk_i) disable iff (rst_i)
        !(w_push && w_full && !w_pop));

    assign req_o        = w_req;
    assign addr_o       = r_addr;
    assign done_o       = r_done;
    assign we_o         = 1'b0;
    assign wdata_o      = '0;
    assign be_o         = '1;
    assign data_valid_o = !w_empty;
    assign data_o       = w_rd.data;
    assign data_last_o  = w_rd.last;

endmodule

// File: tb/tb_sram_stream_reader.sv
// Bench for sram_stream_reader: three builds share one command bus,
// each with its own SRAM model and expected-word scoreboard.
module tb_sram_stream_reader;

    localparam int NWS  [3] = '{1024, 10, 12};
    localparam int LATS [3] = '{1, 3, 0};
    localparam int FDS  [3] = '{4, 5, 2};

    logic        clk = 0;
    logic        rst = 1;
    logic        cmd_valid = 0;
    logic [9:0]  cmd_addr = '0;
    logic [15:0] cmd_len = '0;
    logic        data_ready = 1;

    logic [2:0]   v_ready, v_busy, v_done, v_req, v_valid, v_last, v_we;
    logic [9:0]   v_addr  [3];
    logic [127:0] v_data  [3];
    logic [127:0] v_wdata [3];
    logic [15:0]  v_be    [3];

    int checks = 0;
    int errors = 0;
    bit rnd_on = 0;

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] got,
                         input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int NW  = NWS[g];
        localparam int LAT = LATS[g];
        localparam int FD  = FDS[g];
        localparam int AW  = (NW > 1) ? $clog2(NW) : 1;

        logic          cmd_ready, busy, done, req, we, valid, last;
        logic [AW-1:0] addr;
        logic [127:0]  wdata, rdata, data;
        logic [15:0]   be;

        int unsigned qa[$];
        int unsigned qd[$];
        bit          ql[$];
        int outst = 0;
        int maxo = 0;
        int nreq = 0;
        int ndone = 0;
        bit exp_done = 0;

        sram_stream_reader #(
            .NumWords(NW), .DataWidth(128), .ByteWidth(8),
            .Latency(LAT), .FifoDepth(FD), .LenWidth(16)
        ) u_dut (
            .clk_i(clk), .rst_i(rst),
            .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready),
            .cmd_addr_i(cmd_addr[AW-1:0]), .cmd_len_i(cmd_len),
            .busy_o(busy), .done_o(done),
            .req_o(req), .we_o(we), .addr_o(addr),
            .wdata_o(wdata), .be_o(be), .rdata_i(rdata),
            .data_valid_o(valid), .data_ready_i(data_ready),
            .data_o(data), .data_last_o(last)
        );

        // SRAM preset word[i] = i, returned LAT cycles after the request
        if (LAT == 0) begin : g_m0
            assign rdata = 128'(addr);
        end else begin : g_m
            logic [AW-1:0] p [LAT];
            always @(posedge clk) begin
                p[0] <= addr;
                for (int i = 1; i < LAT; i++) p[i] <= p[i-1];
            end
            assign rdata = 128'(p[LAT-1]);
        end

        assign v_ready[g] = cmd_ready;
        assign v_busy[g]  = busy;
        assign v_done[g]  = done;
        assign v_req[g]   = req;
        assign v_valid[g] = valid;
        assign v_last[g]  = last;
        assign v_we[g]    = we;
        assign v_addr[g]  = 10'(addr);
        assign v_data[g]  = data;
        assign v_wdata[g] = wdata;
        assign v_be[g]    = be;

        always @(negedge clk) begin
            if (rst) begin
                qa.delete();
                qd.delete();
                ql.delete();
                outst = 0;
                exp_done = 0;
            end else begin
                if (done || exp_done)
                    check($sformatf("done%0d", g), done, exp_done);
                if (done) ndone++;
                exp_done = 0;
                if (cmd_valid && cmd_ready) begin
                    if (cmd_len == 0) exp_done = 1;
                    for (int i = 0; i < int'(cmd_len); i++) begin
                        qa.push_back((int'(cmd_addr) + i) % NW);
                        qd.push_back((int'(cmd_addr) + i) % NW);
                        ql.push_back(i == int'(cmd_len) - 1);
                    end
                end
                if (req) begin
                    nreq++;
                    outst++;
                    if (qa.size() == 0)
                        check($sformatf("extra_req%0d", g), req, 0);
                    else
                        check($sformatf("addr%0d", g), addr, qa.pop_front());
                end
                if (valid && data_ready) begin
                    outst--;
                    if (qd.size() == 0) begin
                        check($sformatf("extra_data%0d", g), valid, 0);
                    end else begin
                        bit el;
                        el = ql.pop_front();
                        check($sformatf("data%0d", g), data, 128'(qd.pop_front()));
                        check($sformatf("last%0d", g), last, el);
                        if (el) exp_done = 1;
                    end
                end
                if (outst > maxo) maxo = outst;
            end
        end
    end

    task automatic send(input int a, input int len);
        @(posedge clk); #1;
        cmd_addr  = 10'(a);
        cmd_len   = 16'(len);
        cmd_valid = 1;
        @(posedge clk); #1;
        cmd_valid = 0;
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (!(v_busy == 0 && v_valid == 0) && n < 3000) begin
            @(posedge clk); #1;
            n++;
        end
        check({tag, "_timeout"}, 32'(n < 3000), 1);
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ready"}, v_ready, 0);
        check({tag, "_busy"}, v_busy, 0);
        check({tag, "_done"}, v_done, 0);
        check({tag, "_req"}, v_req, 0);
        check({tag, "_valid"}, v_valid, 0);
        check({tag, "_last"}, v_last, 0);
        check({tag, "_we"}, v_we, 0);
        for (int k = 0; k < 3; k++) begin
            check($sformatf("%s_addr%0d", tag, k), v_addr[k], 0);
            check($sformatf("%s_data%0d", tag, k), v_data[k], 0);
            check($sformatf("%s_wdata%0d", tag, k), v_wdata[k], 0);
            check($sformatf("%s_be%0d", tag, k), v_be[k], 16'hffff);
        end
    endtask

    initial begin
        int n, run;
        int n0 [3];
        int d0 [3];

        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("por");
        rst = 0;
        @(posedge clk); #1;
        check("idle_ready", v_ready, 3'b111);

        // Streaming burst with the consumer always ready
        send(5, 8);
        n = 0;
        while (!v_valid[0] && n < 20) begin @(negedge clk); n++; end
        run = 0;
        while (v_valid[0] && run < 20) begin run++; @(negedge clk); end
        check("burst_run", run, 8);
        wait_idle("t1");

        // Consumer stalled: the credit limit caps issued requests
        data_ready = 0;
        n0[0] = g_dut[0].nreq;
        n0[1] = g_dut[1].nreq;
        n0[2] = g_dut[2].nreq;
        send(5, 8);
        repeat (20) @(posedge clk);
        #1;
        check("stall_req0", g_dut[0].nreq - n0[0], 4);
        check("stall_req1", g_dut[1].nreq - n0[1], 5);
        check("stall_req2", g_dut[2].nreq - n0[2], 2);
        check("stall_req_now", v_req, 0);
        data_ready = 1;
        wait_idle("t2");
        check("total_req0", g_dut[0].nreq - n0[0], 8);
        check("total_req1", g_dut[1].nreq - n0[1], 8);

        // Address wrap on the 10- and 12-word builds
        send(8, 5);
        wait_idle("t3");

        // Zero-length command
        d0[0] = g_dut[0].ndone;
        d0[1] = g_dut[1].ndone;
        d0[2] = g_dut[2].ndone;
        send(0, 0);
        check("len0_ready_a", v_ready, 3'b111);
        check("len0_req_a", v_req, 0);
        @(posedge clk); #1;
        check("len0_ready_b", v_ready, 3'b111);
        check("len0_req_b", v_req, 0);
        repeat (3) @(posedge clk);
        #1;
        check("len0_done0", g_dut[0].ndone - d0[0], 1);
        check("len0_done1", g_dut[1].ndone - d0[1], 1);
        check("len0_done2", g_dut[2].ndone - d0[2], 1);

        // Random consumer backpressure
        void'($urandom(32'd17));
        rnd_on = 1;
        fork
            while (rnd_on) begin
                @(posedge clk); #1;
                if (rnd_on) data_ready = ($urandom_range(0, 3) != 0);
            end
        join_none
        for (int k = 0; k < 4; k++) begin
            send(k, 6 + k);
            wait_idle("t5");
        end
        rnd_on = 0;
        @(posedge clk); #2;
        data_ready = 1;

        // Reset with reads in flight
        data_ready = 0;
        send(0, 8);
        repeat (3) @(posedge clk);
        #1;
        rst = 1;
        #1;
        check_reset_outputs("midrst");
        repeat (3) @(posedge clk);
        #1;
        rst = 0;
        data_ready = 1;
        repeat (8) @(posedge clk);
        #1;
        check("post_rst_valid", v_valid, 0);
        send(0, 2);
        wait_idle("t6");

        check("left0", g_dut[0].qd.size(), 0);
        check("left1", g_dut[1].qd.size(), 0);
        check("left2", g_dut[2].qd.size(), 0);
        check("credit0", 32'(g_dut[0].maxo <= 4), 1);
        check("credit1", 32'(g_dut[1].maxo <= 5), 1);
        check("credit2", 32'(g_dut[2].maxo <= 2), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
